// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and the single-shift helper for lfsr_gen.
package lfsr_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] lfsr_word_t;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [23:0] TAPS_W24 = 24'hE10000;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // Operands are zero-extended to MAX_W; callers keep only their low WIDTH bits.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state, input lfsr_word_t taps);
    logic fb;
    fb = ^(state & taps);
    return {state[MAX_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Handshake/data bundle for lfsr_gen. Period outputs exist only with LFSR_PERIOD_CNT_EN.
interface lfsr_gen_if #(parameter int WIDTH = 8);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] random;
  logic             valid;
  logic             lockup;
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] period_cnt;
  logic             period_hit;

  modport master (output en, load, seed_in, input random, valid, lockup, period_cnt, period_hit);
  modport slave  (input en, load, seed_in, output random, valid, lockup, period_cnt, period_hit);
`else
  modport master (output en, load, seed_in, input random, valid, lockup);
  modport slave  (input en, load, seed_in, output random, valid, lockup);
`endif
endinterface

// File: rtl/lfsr_gen_step_chain.sv
// Combinational chain applying STEPS Fibonacci shifts to a WIDTH-bit state.
module lfsr_step_chain
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter int              STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  localparam lfsr_word_t TAPS_X = MAX_W'(TAPS);

  logic [STEPS:0][WIDTH-1:0] stage;

  assign stage[0] = state_i;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    assign stage[s+1] = WIDTH'(lfsr_step(MAX_W'(stage[s]), TAPS_X));
  end

  assign state_o = stage[STEPS];

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lockup recovery and valid strobe.
// Optional period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter int               STEPS = 1
) (
  input  logic      clk,
  input  logic      rst,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] state_q, state_d, step_nxt;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;

  lfsr_step_chain #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_chain (
    .state_i (state_q),
    .state_o (step_nxt)
  );

  // Load outranks advance; an all-zero result from either path falls back to SEED.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    lockup_d = 1'b0;
    if (bus.load) begin
      valid_d = 1'b1;
      if (bus.seed_in == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = bus.seed_in;
      end
    end else if (bus.en) begin
      valid_d = 1'b1;
      if (step_nxt == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = step_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.random = state_q;
  assign bus.valid  = valid_q;
  assign bus.lockup = lockup_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;

  // ref_q holds the state seen right after the last reset, load or recovery.
  always_comb begin
    ref_d = ref_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (bus.load || lockup_d) begin
      ref_d = state_d;
      cnt_d = '0;
    end else if (bus.en) begin
      if (state_d == ref_q) begin
        cnt_d = '0;
        hit_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= SEED;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign bus.period_cnt = cnt_q;
  assign bus.period_hit = hit_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed-vector bench for lfsr_gen (8-bit, taps B8) plus STEPS=2 and TAPS=0 corner cases.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(8)) if_a ();
  lfsr_gen_if #(.WIDTH(8)) if_b ();
  lfsr_gen_if #(.WIDTH(8)) if_z ();

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .STEPS(1)) u_dut  (.clk(clk), .rst(rst), .bus(if_a));
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .STEPS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if_b));
  lfsr_gen #(.WIDTH(8), .TAPS(8'h00), .SEED(8'hFF), .STEPS(1)) u_dutz (.clk(clk), .rst(rst), .bus(if_z));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, en, load;
    logic [7:0] seed;
    logic [7:0] exp_rnd;
    logic       exp_vld, exp_lck;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int early;
    rst = 1'b1;
    if_a.en = 1'b0; if_a.load = 1'b0; if_a.seed_in = '0;
    if_b.en = 1'b0; if_b.load = 1'b0; if_b.seed_in = '0;
    if_z.en = 1'b0; if_z.load = 1'b0; if_z.seed_in = '0;

    //          rst   en    load  seed   rnd    vld   lck   cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0, 8'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFC, 1'b1, 1'b0, 8'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hF8, 1'b1, 1'b0, 8'd3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hF0, 1'b1, 1'b0, 8'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hE1, 1'b1, 1'b0, 8'd5};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hE1, 1'b0, 1'b0, 8'd5};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hB4, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h69, 1'b1, 1'b0, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0, 8'd1};

    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; if_a.en = vecs[i].en; if_a.load = vecs[i].load; if_a.seed_in = vecs[i].seed;
      tick();
      chk($sformatf("vec%0d_random", i), 32'(if_a.random), 32'(vecs[i].exp_rnd));
      chk($sformatf("vec%0d_valid", i),  32'(if_a.valid),  32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_lockup", i), 32'(if_a.lockup), 32'(vecs[i].exp_lck));
`ifdef LFSR_PERIOD_CNT_EN
      chk($sformatf("vec%0d_pcnt", i),   32'(if_a.period_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_phit", i),   32'(if_a.period_hit), 32'd0);
`endif
    end
    if_a.en = 1'b0; if_a.load = 1'b0;

    // Full period from FF: 255 advances, FF must not reappear earlier.
    rst = 1'b1; tick(); rst = 1'b0;
    early = 0;
    if_a.en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 255 && if_a.random == 8'hFF) early++;
`ifdef LFSR_PERIOD_CNT_EN
      if (i == 254) begin
        chk("period_cnt_254", 32'(if_a.period_cnt), 32'd254);
        chk("period_hit_254", 32'(if_a.period_hit), 32'd0);
      end
`endif
    end
    chk("period_early_ff", 32'(early), 32'd0);
    chk("period_return_ff", 32'(if_a.random), 32'hFF);
`ifdef LFSR_PERIOD_CNT_EN
    chk("period_hit_255", 32'(if_a.period_hit), 32'd1);
    chk("period_cnt_255", 32'(if_a.period_cnt), 32'd0);
`endif
    if_a.en = 1'b0;
    tick();
    chk("period_idle_valid", 32'(if_a.valid), 32'd0);
`ifdef LFSR_PERIOD_CNT_EN
    chk("period_hit_drop", 32'(if_a.period_hit), 32'd0);
`endif

    // STEPS=2: a single enable pulse moves FF two shifts to FC.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s2_reset_random", 32'(if_b.random), 32'hFF);
    if_b.en = 1'b1; tick(); if_b.en = 1'b0;
    chk("s2_random", 32'(if_b.random), 32'hFC);
    chk("s2_valid",  32'(if_b.valid),  32'd1);
    tick();
    chk("s2_random_hold", 32'(if_b.random), 32'hFC);
    chk("s2_valid_drop",  32'(if_b.valid),  32'd0);

    // TAPS=0: state drains to zero on the eighth shift and is replaced by SEED.
    rst = 1'b1; tick(); rst = 1'b0;
    if_z.en = 1'b1;
    begin
      logic [7:0] zexp[8];
      zexp = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'hFF};
      for (int i = 0; i < 8; i++) begin
        tick();
        chk($sformatf("z%0d_random", i), 32'(if_z.random), 32'(zexp[i]));
        chk($sformatf("z%0d_lockup", i), 32'(if_z.lockup), (i == 7) ? 32'd1 : 32'd0);
      end
    end
    tick();
    chk("z_after_random", 32'(if_z.random), 32'hFE);
    chk("z_after_lockup", 32'(if_z.lockup), 32'd0);
    if_z.en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
